noc_pipelined_credit_link: RTL and testbench

- Parametrised array of NUM_LINKS router-to-router NoC links.
- Each link carries flits (data, dest, is_tail, send) downstream and credits upstream.
- Each direction has NUM_PIPELINE register stages, so long inter-router wires can be retimed.
- Each link has an upstream-side credit monitor that checks the credit protocol against FLIT_BUFFER_DEPTH, and saturating flit and packet counters.
- Instantiated between neighbouring router_wrap instances. It replaces the unpipelined direct assignments between router output ports and neighbour inputs.

---
 rtl/noc_pipelined_credit_link.sv | 164 ++++++++++++++++
 tb/tb_noc_pipelined_credit_link.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pipelined_credit_link.sv
// Array of independent router-to-router NoC links. Each link retimes flits downstream and
// credits upstream through NUM_PIPELINE register stages, and keeps an upstream-side credit
// monitor plus saturating flit/packet statistics.
module noc_pipelined_credit_link #(
    parameter int unsigned NUM_LINKS         = 4,
    parameter int unsigned FLIT_WIDTH        = 64,
    parameter int unsigned DEST_WIDTH        = 4,
    parameter int unsigned NUM_PIPELINE      = 2,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8,
    parameter int unsigned CNT_WIDTH         = 16,
    parameter int unsigned CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                                     clk_noc,
    input  logic                                     rst_noc_sync,
    input  logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0]     data_in,
    input  logic [0:NUM_LINKS-1][DEST_WIDTH-1:0]     dest_in,
    input  logic [0:NUM_LINKS-1]                     is_tail_in,
    input  logic [0:NUM_LINKS-1]                     send_in,
    output logic [0:NUM_LINKS-1]                     credit_out,
    output logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0]     data_out,
    output logic [0:NUM_LINKS-1][DEST_WIDTH-1:0]     dest_out,
    output logic [0:NUM_LINKS-1]                     is_tail_out,
    output logic [0:NUM_LINKS-1]                     send_out,
    input  logic [0:NUM_LINKS-1]                     credit_in,
    output logic [0:NUM_LINKS-1][CREDIT_WIDTH-1:0]   credits_avail,
    output logic [0:NUM_LINKS-1]                     err_overrun,
    output logic [0:NUM_LINKS-1]                     err_excess_credit,
    output logic [0:NUM_LINKS-1][CNT_WIDTH-1:0]      flit_count,
    output logic [0:NUM_LINKS-1][CNT_WIDTH-1:0]      pkt_count
);

    localparam logic [CREDIT_WIDTH-1:0] CreditMax = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    for (genvar l = 0; l < NUM_LINKS; l++) begin : g_link

        if (NUM_PIPELINE == 0) begin : g_bypass
            assign send_out[l]    = send_in[l];
            assign is_tail_out[l] = is_tail_in[l];
            assign dest_out[l]    = dest_in[l];
            assign data_out[l]    = data_in[l];
            assign credit_out[l]  = credit_in[l];
        end else begin : g_pipe
            logic [NUM_PIPELINE-1:0]                 send_q, send_d;
            logic [NUM_PIPELINE-1:0]                 tail_q, tail_d;
            logic [NUM_PIPELINE-1:0][DEST_WIDTH-1:0] dest_q, dest_d;
            logic [NUM_PIPELINE-1:0][FLIT_WIDTH-1:0] data_q, data_d;
            logic [NUM_PIPELINE-1:0]                 credit_q, credit_d;

            // Shift every stage forward each cycle; payload only moves alongside a valid flit
            // so idle cycles do not toggle the wide data registers.
            always_comb begin
                send_d   = send_q;
                tail_d   = tail_q;
                dest_d   = dest_q;
                data_d   = data_q;
                credit_d = credit_q;

                send_d[0]   = send_in[l];
                credit_d[0] = credit_in[l];
                if (send_in[l]) begin
                    tail_d[0] = is_tail_in[l];
                    dest_d[0] = dest_in[l];
                    data_d[0] = data_in[l];
                end

                for (int k = 1; k < NUM_PIPELINE; k++) begin
                    send_d[k]   = send_q[k-1];
                    credit_d[k] = credit_q[k-1];
                    if (send_q[k-1]) begin
                        tail_d[k] = tail_q[k-1];
                        dest_d[k] = dest_q[k-1];
                        data_d[k] = data_q[k-1];
                    end
                end
            end

            // Pipeline registers; reset drops any in-flight flits and credits.
            always_ff @(posedge clk_noc) begin
                if (rst_noc_sync) begin
                    send_q   <= '0;
                    tail_q   <= '0;
                    dest_q   <= '0;
                    data_q   <= '0;
                    credit_q <= '0;
                end else begin
                    send_q   <= send_d;
                    tail_q   <= tail_d;
                    dest_q   <= dest_d;
                    data_q   <= data_d;
                    credit_q <= credit_d;
                end
            end

            assign send_out[l]    = send_q[NUM_PIPELINE-1];
            assign is_tail_out[l] = tail_q[NUM_PIPELINE-1];
            assign dest_out[l]    = dest_q[NUM_PIPELINE-1];
            assign data_out[l]    = data_q[NUM_PIPELINE-1];
            assign credit_out[l]  = credit_q[NUM_PIPELINE-1];
        end

        logic [CREDIT_WIDTH-1:0] cred_q, cred_d;
        logic                    ovr_q, ovr_d;
        logic                    exc_q, exc_d;
        logic [CNT_WIDTH-1:0]    flit_q, flit_d;
        logic [CNT_WIDTH-1:0]    pkt_q, pkt_d;

        // Credit accounting against the delayed credit, sticky protocol errors, and
        // saturating statistics. The monitor observes only; it never gates traffic.
        always_comb begin
            cred_d = cred_q;
            ovr_d  = ovr_q;
            exc_d  = exc_q;
            flit_d = flit_q;
            pkt_d  = pkt_q;

            if (send_in[l] && (cred_q == '0)) begin
                ovr_d = 1'b1;
            end

            if (send_in[l] && !credit_out[l]) begin
                if (cred_q != '0) begin
                    cred_d = cred_q - 1'b1;
                end
            end else if (!send_in[l] && credit_out[l]) begin
                if (cred_q == CreditMax) begin
                    exc_d = 1'b1;
                end else begin
                    cred_d = cred_q + 1'b1;
                end
            end

            if (send_in[l] && (flit_q != '1)) begin
                flit_d = flit_q + 1'b1;
            end
            if (send_in[l] && is_tail_in[l] && (pkt_q != '1)) begin
                pkt_d = pkt_q + 1'b1;
            end
        end

        // Monitor and statistics registers.
        always_ff @(posedge clk_noc) begin
            if (rst_noc_sync) begin
                cred_q <= CreditMax;
                ovr_q  <= 1'b0;
                exc_q  <= 1'b0;
                flit_q <= '0;
                pkt_q  <= '0;
            end else begin
                cred_q <= cred_d;
                ovr_q  <= ovr_d;
                exc_q  <= exc_d;
                flit_q <= flit_d;
                pkt_q  <= pkt_d;
            end
        end

        assign credits_avail[l]     = cred_q;
        assign err_overrun[l]       = ovr_q;
        assign err_excess_credit[l] = exc_q;
        assign flit_count[l]        = flit_q;
        assign pkt_count[l]         = pkt_q;
    end

endmodule

// File: tb/tb_noc_pipelined_credit_link.sv
// Directed bench for noc_pipelined_credit_link: a two-stage link (A), a two-stage link with
// 4-bit statistics (B) and a zero-stage pass-through link (C).
module tb_noc_pipelined_credit_link;

    localparam int unsigned NL = 4;
    localparam int unsigned FW = 64;
    localparam int unsigned DW = 4;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: NUM_PIPELINE=2, CNT_WIDTH=16
    logic [0:NL-1][FW-1:0] data_a, data_out_a;
    logic [0:NL-1][DW-1:0] dest_a, dest_out_a;
    logic [0:NL-1]         tail_a, send_a, credit_a, tail_out_a, send_out_a, credit_out_a;
    logic [0:NL-1][CW-1:0] avail_a;
    logic [0:NL-1]         ovr_a, exc_a;
    logic [0:NL-1][15:0]   flit_a, pkt_a;

    // Instance B: NUM_PIPELINE=2, CNT_WIDTH=4
    logic [0:NL-1][FW-1:0] data_b, data_out_b;
    logic [0:NL-1][DW-1:0] dest_b, dest_out_b;
    logic [0:NL-1]         tail_b, send_b, credit_b, tail_out_b, send_out_b, credit_out_b;
    logic [0:NL-1][CW-1:0] avail_b;
    logic [0:NL-1]         ovr_b, exc_b;
    logic [0:NL-1][3:0]    flit_b, pkt_b;

    // Instance C: NUM_PIPELINE=0
    logic [0:NL-1][FW-1:0] data_c, data_out_c;
    logic [0:NL-1][DW-1:0] dest_c, dest_out_c;
    logic [0:NL-1]         tail_c, send_c, credit_c, tail_out_c, send_out_c, credit_out_c;
    logic [0:NL-1][CW-1:0] avail_c;
    logic [0:NL-1]         ovr_c, exc_c;
    logic [0:NL-1][15:0]   flit_c, pkt_c;

    noc_pipelined_credit_link #(.NUM_PIPELINE(2), .CNT_WIDTH(16)) u_dut_a (
        .clk_noc(clk), .rst_noc_sync(rst),
        .data_in(data_a), .dest_in(dest_a), .is_tail_in(tail_a), .send_in(send_a),
        .credit_out(credit_out_a), .data_out(data_out_a), .dest_out(dest_out_a),
        .is_tail_out(tail_out_a), .send_out(send_out_a), .credit_in(credit_a),
        .credits_avail(avail_a), .err_overrun(ovr_a), .err_excess_credit(exc_a),
        .flit_count(flit_a), .pkt_count(pkt_a)
    );

    noc_pipelined_credit_link #(.NUM_PIPELINE(2), .CNT_WIDTH(4)) u_dut_b (
        .clk_noc(clk), .rst_noc_sync(rst),
        .data_in(data_b), .dest_in(dest_b), .is_tail_in(tail_b), .send_in(send_b),
        .credit_out(credit_out_b), .data_out(data_out_b), .dest_out(dest_out_b),
        .is_tail_out(tail_out_b), .send_out(send_out_b), .credit_in(credit_b),
        .credits_avail(avail_b), .err_overrun(ovr_b), .err_excess_credit(exc_b),
        .flit_count(flit_b), .pkt_count(pkt_b)
    );

    noc_pipelined_credit_link #(.NUM_PIPELINE(0), .CNT_WIDTH(16)) u_dut_c (
        .clk_noc(clk), .rst_noc_sync(rst),
        .data_in(data_c), .dest_in(dest_c), .is_tail_in(tail_c), .send_in(send_c),
        .credit_out(credit_out_c), .data_out(data_out_c), .dest_out(dest_out_c),
        .is_tail_out(tail_out_c), .send_out(send_out_c), .credit_in(credit_c),
        .credits_avail(avail_c), .err_overrun(ovr_c), .err_excess_credit(exc_c),
        .flit_count(flit_c), .pkt_count(pkt_c)
    );

    typedef struct {
        logic [0:NL-1] send;
        logic [0:NL-1] tail;
        logic [0:NL-1] credit;
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic [0:NL-1] exp_send;
        logic [0:NL-1] exp_tail;
        logic [0:NL-1] exp_credit;
    } vec_t;

    vec_t vecs [5];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   min_avail;
        int   seen;
        logic arr_prev;
        logic [63:0] last_data;

        vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 64'h0, 4'h0, 4'b0000, 4'b0000, 4'b0000};
        vecs[1] = '{4'b1010, 4'b1000, 4'b0101, 64'h0123_4567_89AB_CDEF, 4'h3,
                    4'b1010, 4'b1000, 4'b0101};
        vecs[2] = '{4'b1111, 4'b1111, 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF,
                    4'b1111, 4'b1111, 4'b1111};
        vecs[3] = '{4'b0001, 4'b0001, 4'b1000, 64'hA5A5_5A5A_0F0F_F0F0, 4'h9,
                    4'b0001, 4'b0001, 4'b1000};
        vecs[4] = '{4'b0110, 4'b0100, 4'b0010, 64'h1, 4'h6, 4'b0110, 4'b0100, 4'b0010};

        data_a = '0; dest_a = '0; tail_a = '0; send_a = '0; credit_a = '0;
        data_b = '0; dest_b = '0; tail_b = '0; send_b = '0; credit_b = '0;
        data_c = '0; dest_c = '0; tail_c = '0; send_c = '0; credit_c = '0;

        // Reset held 3 cycles with every link trying to send.
        rst = 1'b1;
        send_a = 4'hF;
        tail_a = 4'hF;
        repeat (3) tick();
        check("rst_send_out", send_out_a, 0);
        check("rst_credit_out", credit_out_a, 0);
        for (int l = 0; l < NL; l++) check($sformatf("rst_avail[%0d]", l), avail_a[l], 8);
        rst = 1'b0;
        send_a = '0;
        tail_a = '0;
        tick();
        for (int l = 0; l < NL; l++) begin
            check($sformatf("rel_flit[%0d]", l), flit_a[l], 0);
            check($sformatf("rel_pkt[%0d]", l), pkt_a[l], 0);
        end
        check("rel_err", {ovr_a, exc_a}, 0);

        // Latency: one single-flit packet on link 1 appears exactly two cycles later.
        send_a[1] = 1'b1; data_a[1] = 64'hDEAD_BEEF; tail_a[1] = 1'b1; dest_a[1] = 4'h5;
        tick();
        send_a[1] = 1'b0; data_a[1] = '0; tail_a[1] = 1'b0; dest_a[1] = '0;
        check("lat_t1_send", send_out_a, 0);
        check("lat_avail1", avail_a[1], 7);
        check("lat_flit1", flit_a[1], 1);
        check("lat_pkt1", pkt_a[1], 1);
        tick();
        check("lat_t2_send", send_out_a, 4'b0100);
        check("lat_t2_data", data_out_a[1], 64'hDEAD_BEEF);
        check("lat_t2_tail", tail_out_a[1], 1);
        check("lat_t2_dest", dest_out_a[1], 4'h5);
        tick();
        check("lat_t3_send", send_out_a[1], 0);

        // Credit loop on link 0: the round trip (2 forward + 1 downstream + 2 reverse stages)
        // lets five flits be outstanding, so the count bottoms out at 3 rather than 0.
        min_avail = 8;
        arr_prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            credit_a[0] = arr_prev;
            arr_prev = send_out_a[0];
            send_a[0] = (i < 8);
            tick();
            if (int'(avail_a[0]) < min_avail) min_avail = int'(avail_a[0]);
        end
        credit_a[0] = 1'b0;
        check("loop_min_avail", 64'(min_avail), 3);
        check("loop_final_avail", avail_a[0], 8);
        check("loop_ovr0", ovr_a[0], 0);
        check("loop_exc0", exc_a[0], 0);
        check("loop_flit0", flit_a[0], 8);

        // Overrun on link 2: nine flits, no credits.
        seen = 0;
        last_data = '0;
        for (int i = 0; i < 13; i++) begin
            send_a[2] = (i < 9);
            data_a[2] = 64'(i);
            tick();
            if (send_out_a[2]) begin
                seen++;
                last_data = data_out_a[2];
            end
            if (i == 7) begin
                check("ovr_avail_8th", avail_a[2], 0);
                check("ovr_flag_8th", ovr_a[2], 0);
            end
            if (i == 8) begin
                check("ovr_flag_9th", ovr_a[2], 1);
                check("ovr_avail_9th", avail_a[2], 0);
            end
        end
        send_a[2] = 1'b0;
        check("ovr_seen", 64'(seen), 9);
        check("ovr_last_data", last_data, 8);
        check("ovr_sticky", ovr_a, 4'b0010);

        // Excess credit on link 3: one stray credit pulse.
        credit_a[3] = 1'b1;
        tick();
        credit_a[3] = 1'b0;
        tick();
        check("exc_credit_out", credit_out_a, 4'b0001);
        check("exc_flag_early", exc_a[3], 0);
        tick();
        check("exc_flag", exc_a, 4'b0001);
        check("exc_avail3", avail_a[3], 8);
        tick();
        check("exc_sticky", exc_a[3], 1);

        // Saturation on B: 20 single-flit packets; coincident send/credit keep the count flat.
        arr_prev = 1'b0;
        for (int i = 0; i < 28; i++) begin
            credit_b[0] = arr_prev;
            arr_prev = send_out_b[0];
            send_b[0] = (i < 20);
            tail_b[0] = (i < 20);
            tick();
            if (i >= 4 && i <= 19) check($sformatf("sat_avail_c%0d", i + 1), avail_b[0], 3);
        end
        credit_b[0] = 1'b0;
        send_b[0] = 1'b0;
        tail_b[0] = 1'b0;
        check("sat_flit", flit_b[0], 15);
        check("sat_pkt", pkt_b[0], 15);
        check("sat_final_avail", avail_b[0], 8);
        check("sat_err", {ovr_b, exc_b}, 0);

        // Pass-through table on C.
        for (int v = 0; v < 5; v++) begin
            send_c = vecs[v].send;
            tail_c = vecs[v].tail;
            credit_c = vecs[v].credit;
            for (int l = 0; l < NL; l++) begin
                data_c[l] = vecs[v].data + 64'(l);
                dest_c[l] = vecs[v].dest ^ DW'(l);
            end
            #1;
            check($sformatf("pt%0d_send", v), send_out_c, vecs[v].exp_send);
            check($sformatf("pt%0d_tail", v), tail_out_c, vecs[v].exp_tail);
            check($sformatf("pt%0d_credit", v), credit_out_c, vecs[v].exp_credit);
            for (int l = 0; l < NL; l++) begin
                check($sformatf("pt%0d_data[%0d]", v, l), data_out_c[l],
                      vecs[v].data + 64'(l));
                check($sformatf("pt%0d_dest[%0d]", v, l), dest_out_c[l],
                      64'(vecs[v].dest ^ DW'(l)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
